// File: rtl/sdr_tgen_pkg.sv
// Shared types and constants for the SDRAM Wishbone traffic generator.
// Optional LFSR data pattern is selected by SDR_TGEN_LFSR_EN.
package sdr_tgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_DONE
  } state_t;

  localparam logic [2:0]  CTI_INCR  = 3'b010;
  localparam logic [2:0]  CTI_EOB   = 3'b111;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam int unsigned ADDR_STEP = 4;

  // One right shift of the Galois LFSR
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'd0);
  endfunction

endpackage

// File: rtl/sdr_tgen_pattern.sv
// Data pattern source: incrementing word, or Galois LFSR when
// SDR_TGEN_LFSR_EN is defined. Serves write data and read expectations.
module sdr_tgen_pattern
  import sdr_tgen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] cur_word
);

  logic [31:0] r_word;
  logic [31:0] w_seed;
  logic [31:0] w_next;

`ifdef SDR_TGEN_LFSR_EN
  // An all-zero LFSR state would lock up, so zero seeds become 1
  assign w_seed = (seed == 32'd0) ? 32'd1 : seed;
  assign w_next = lfsr_next(r_word);
`else
  assign w_seed = seed;
  assign w_next = r_word + 32'd1;
`endif

  // Load on command accept, step once per acknowledged beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= 32'd0;
    end else if (load) begin
      r_word <= w_seed;
    end else if (advance) begin
      r_word <= w_next;
    end
  end

  assign cur_word = r_word;

endmodule

// File: rtl/sdr_wb_traffic_gen.sv
// Wishbone burst master generating write / read-and-check traffic
// for SDRAM bring-up. Pattern mode selected by SDR_TGEN_LFSR_EN.
module sdr_wb_traffic_gen
  import sdr_tgen_pkg::*;
#(
  parameter int APP_AW    = 26,
  parameter int dw        = 32,
  parameter int TIMEOUT_W = 12
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [31:0]       cmd_seed,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [APP_AW-1:0] first_err_addr,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic [dw/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [dw-1:0]     wb_dat_i
);

  localparam logic [TIMEOUT_W-1:0] WD_LAST =
    TIMEOUT_W'((1 << TIMEOUT_W) - 2);

  state_t              r_state;
  logic                r_cyc;
  logic                r_wr;
  logic [APP_AW-1:0]   r_addr;
  logic [8:0]          r_beats;
  logic [TIMEOUT_W-1:0] r_wdog;
  logic                r_done;
  logic                r_timeout;
  logic [15:0]         r_err_cnt;
  logic [APP_AW-1:0]   r_first_err;

  logic                w_accept;
  logic                w_ack;
  logic                w_last;
  logic                w_mis;
  logic [31:0]         w_cur;

  assign w_accept = cmd_valid & (r_state == ST_IDLE);
  assign w_ack    = wb_ack_i & r_cyc;
  assign w_last   = (r_beats == 9'd1);
  assign w_mis    = w_ack & ~r_wr & (wb_dat_i != w_cur);

  sdr_tgen_pattern u_pat (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (w_accept),
    .seed     (cmd_seed),
    .advance  (w_ack),
    .cur_word (w_cur)
  );

  // Command sequencer: accept, burst with watchdog, one-cycle done
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_cyc       <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_beats     <= 9'd0;
      r_wdog      <= '0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_cnt   <= 16'd0;
      r_first_err <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_state     <= ST_BUS;
            r_cyc       <= 1'b1;
            r_wr        <= cmd_wr;
            r_addr      <= cmd_addr & ~APP_AW'(3);
            r_beats     <= (cmd_len == 8'd0) ? 9'd256
                                             : {1'b0, cmd_len};
            r_wdog      <= '0;
            r_timeout   <= 1'b0;
            r_err_cnt   <= 16'd0;
            r_first_err <= '0;
          end
        end
        ST_BUS: begin
          if (w_ack) begin
            r_addr  <= r_addr + APP_AW'(ADDR_STEP);
            r_beats <= r_beats - 9'd1;
            r_wdog  <= '0;
            if (w_mis) begin
              if (r_err_cnt != 16'hFFFF)
                r_err_cnt <= r_err_cnt + 16'd1;
              if (r_err_cnt == 16'd0)
                r_first_err <= r_addr;
            end
            if (w_last) begin
              r_cyc   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end else if (r_wdog == WD_LAST) begin
            r_cyc     <= 1'b0;
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_wdog <= r_wdog + TIMEOUT_W'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready      = (r_state == ST_IDLE);
  assign done           = r_done;
  assign timeout        = r_timeout;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err;
  assign wb_cyc_o       = r_cyc;
  assign wb_stb_o       = r_cyc;
  assign wb_we_o        = r_cyc & r_wr;
  assign wb_addr_o      = r_addr;
  assign wb_dat_o       = (r_cyc & r_wr) ? w_cur : '0;
  assign wb_sel_o       = '1;
  assign wb_cti_o       = !r_cyc ? 3'b000
                        : (w_last ? CTI_EOB : CTI_INCR);

endmodule

// File: tb/tb_sdr_wb_traffic_gen.sv
// Randomized bench for sdr_wb_traffic_gen with a transaction-level
// reference model and a memory-backed Wishbone slave.
module tb_sdr_wb_traffic_gen;

  localparam int AW = 26;
  localparam int TW = 4;
  localparam int TO = 15;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [31:0]   cmd_seed;
  logic          done;
  logic          timeout;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err_addr;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic          wb_ack_i;
  logic [31:0]   wb_dat_i;

  sdr_wb_traffic_gen #(
    .APP_AW(AW), .dw(32), .TIMEOUT_W(TW)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .done(done), .timeout(timeout),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i),
    .wb_dat_i(wb_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model state
  bit            g_run = 1'b0;
  logic          g_wr;
  logic [AW-1:0] g_base;
  int            g_len;
  logic [31:0]   g_cur;
  int            g_beat;
  int            g_noack;
  int            g_pct;
  int            g_cycles;
  int            exp_err;
  logic [AW-1:0] exp_first;
  bit            exp_first_set;
  logic [AW-1:0] la [256];
  logic [31:0]   ld [256];
  logic [2:0]    lc [256];
  logic [31:0]   mem [int unsigned];

  function automatic logic [31:0] pstep(input logic [31:0] v);
`ifdef SDR_TGEN_LFSR_EN
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'd0);
`else
    return v + 32'd1;
`endif
  endfunction

  function automatic logic [31:0] pinit(input logic [31:0] s);
`ifdef SDR_TGEN_LFSR_EN
    return (s == 32'd0) ? 32'd1 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [31:0] memrd(input logic [AW-1:0] a);
    int unsigned k;
    k = 32'(a) >> 2;
    if (mem.exists(k)) return mem[k];
    return {6'd0, a} ^ 32'h5A5A_5A5A;
  endfunction

  // Slave + compare process, all on the falling edge
  bit            s_exp_cyc;
  logic          s_ack;
  logic [31:0]   s_rd;
  logic [AW-1:0] s_a;

  always @(negedge clk) begin
    s_ack = 1'b0;
    s_rd  = $urandom;
    if (g_run) begin
      s_exp_cyc = (g_beat < g_len) && (g_noack < TO);
      chk("cyc", wb_cyc_o, s_exp_cyc);
      if (s_exp_cyc) begin
        s_a = g_base + AW'(4 * g_beat);
        chk("stb", wb_stb_o, 1'b1);
        chk("we", wb_we_o, g_wr);
        chk("addr", wb_addr_o, s_a);
        chk("cti", wb_cti_o,
            (g_beat == g_len - 1) ? 3'b111 : 3'b010);
        chk("dat_o", wb_dat_o, g_wr ? g_cur : 32'd0);
        chk("busy_done", done, 1'b0);
        chk("busy_ready", cmd_ready, 1'b0);
        g_cycles++;
        s_ack = (int'($urandom_range(99)) < g_pct);
        if (s_ack) begin
          la[g_beat] = wb_addr_o;
          ld[g_beat] = wb_dat_o;
          lc[g_beat] = wb_cti_o;
          if (g_wr) begin
            mem[32'(s_a) >> 2] = g_cur;
          end else begin
            s_rd = memrd(s_a);
            if (s_rd != g_cur) begin
              if (exp_err < 65535) exp_err++;
              if (!exp_first_set) begin
                exp_first     = s_a;
                exp_first_set = 1'b1;
              end
            end
          end
          g_cur = pstep(g_cur);
          g_beat++;
          g_noack = 0;
        end else begin
          g_noack++;
        end
      end else begin
        chk("done_pulse", done, 1'b1);
        chk("done_ready", cmd_ready, 1'b0);
        g_run = 1'b0;
        s_ack = (int'($urandom_range(99)) < 30);
      end
    end else begin
      if (!rst) chk("idle_done", done, 1'b0);
      s_ack = (int'($urandom_range(99)) < 20);
    end
    wb_ack_i = s_ack;
    wb_dat_i = s_rd;
  end

  task automatic start_cmd(input bit wr,
                           input logic [AW-1:0] addr,
                           input logic [7:0] len,
                           input logic [31:0] seed,
                           input int pct);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_seed  = seed;
    chk("ready_pre", cmd_ready, 1'b1);
    @(posedge clk);
    g_wr          = wr;
    g_base        = addr & ~AW'(3);
    g_len         = (len == 8'd0) ? 256 : int'(len);
    g_cur         = pinit(seed);
    g_beat        = 0;
    g_noack       = 0;
    g_pct         = pct;
    g_cycles      = 0;
    exp_err       = 0;
    exp_first     = '0;
    exp_first_set = 1'b0;
    g_run         = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("acc_timeout", timeout, 1'b0);
    chk("acc_errcnt", err_cnt, 16'd0);
    chk("acc_first", first_err_addr, '0);
  endtask

  task automatic finish_cmd();
    int n;
    n = 0;
    while (g_run && n < 4000) begin
      @(posedge clk);
      n++;
    end
    if (g_run) begin
      chk("done_wait_bound", 1'b0, 1'b1);
      g_run = 1'b0;
    end
    @(negedge clk);
    chk("end_ready", cmd_ready, 1'b1);
    chk("end_cyc", wb_cyc_o, 1'b0);
    chk("end_errcnt", err_cnt, 16'(exp_err));
    chk("end_first", first_err_addr, exp_first);
    chk("end_timeout", timeout, (g_noack >= TO) ? 1'b1 : 1'b0);
  endtask

  task automatic run_cmd(input bit wr,
                         input logic [AW-1:0] addr,
                         input logic [7:0] len,
                         input logic [31:0] seed,
                         input int pct);
    start_cmd(wr, addr, len, seed, pct);
    finish_cmd();
  endtask

  logic [31:0] sd [4];

  initial begin
    int n;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_len   = 8'd0;
    cmd_seed  = 32'd0;
    wb_ack_i  = 1'b0;
    wb_dat_i  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_we", wb_we_o, 1'b0);
    chk("rst_addr", wb_addr_o, '0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_sel", wb_sel_o, 4'hF);
    chk("rst_cti", wb_cti_o, 3'b000);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_errcnt", err_cnt, 16'd0);
    chk("rst_first", first_err_addr, '0);
    rst = 1'b0;

    run_cmd(1'b1, 26'h0000100, 8'd4, 32'hA000_0000, 70);
    chk("t1_a0", la[0], 26'h100);
    chk("t1_a3", la[3], 26'h10C);
    chk("t1_c0", lc[0], 3'b010);
    chk("t1_c2", lc[2], 3'b010);
    chk("t1_c3", lc[3], 3'b111);
`ifndef SDR_TGEN_LFSR_EN
    chk("t1_d0", ld[0], 32'hA000_0000);
    chk("t1_d3", ld[3], 32'hA000_0003);
`endif

    run_cmd(1'b0, 26'h0000100, 8'd4, 32'hA000_0000, 80);
    chk("t2_err", err_cnt, 16'd0);

    run_cmd(1'b0, 26'h0000100, 8'd4, 32'hA000_0001, 80);
`ifndef SDR_TGEN_LFSR_EN
    chk("t3_err", err_cnt, 16'd4);
    chk("t3_first", first_err_addr, 26'h100);
`endif

    run_cmd(1'b1, 26'h3FFFFFC, 8'd0, $urandom, 85);
    chk("t4_beats", g_beat, 256);
    chk("t4_a0", la[0], 26'h3FFFFFC);
    chk("t4_a1", la[1], 26'h0000000);
    chk("t4_c254", lc[254], 3'b010);
    chk("t4_c255", lc[255], 3'b111);

    run_cmd(1'b0, 26'h0000400, 8'd8, 32'd5, 0);
    chk("t5_cycles", g_cycles, TO);
    chk("t5_timeout", timeout, 1'b1);
    chk("t5_beats", g_beat, 0);

    run_cmd(1'b1, 26'h0000500, 8'd2, 32'h1234_5678, 100);
    chk("t6_timeout", timeout, 1'b0);

    start_cmd(1'b1, 26'h0000600, 8'd8, 32'h0BAD_F00D, 100);
    n = 0;
    while (g_beat < 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("t7_reach_beat2", (g_beat >= 2) ? 1'b1 : 1'b0, 1'b1);
    g_run = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t7_cyc", wb_cyc_o, 1'b0);
    chk("t7_stb", wb_stb_o, 1'b0);
    chk("t7_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    run_cmd(1'b1, 26'h0000700, 8'd4, 32'd0, 90);
`ifdef SDR_TGEN_LFSR_EN
    chk("t7_d0", ld[0], 32'h0000_0001);
`else
    chk("t7_d0", ld[0], 32'h0000_0000);
`endif

    sd[0] = 32'h0000_0000;
    sd[1] = 32'hFFFF_FFFE;
    sd[2] = 32'hDEAD_BEEF;
    sd[3] = 32'h1357_9BDF;
    for (int i = 0; i < 30; i++) begin
      bit wr;
      int pct;
      wr  = $urandom_range(1);
      pct = (int'($urandom_range(9)) == 0) ? 0
          : int'($urandom_range(100, 60));
      run_cmd(wr, 26'h200 + AW'($urandom_range(31) * 4 + $urandom_range(3)),
              8'($urandom_range(20, 1)), sd[$urandom_range(3)], pct);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
